// File: rtl/keypad_matrix_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scan_if
// Description : Keypad-side signal bundle for the 4x4 matrix scanner.
//               master = keypad / host side, slave = scanner side.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_matrix_scan_if;
  logic [3:0] Row_In;       // rows, active-low, pulled up
  logic [3:0] Col_Out;      // column drive, active-low, one-cold
  logic [3:0] Key_Code;     // last accepted single key, row*4 + col
  logic       Key_Valid;    // one-cycle strobe on a new single-key press
  logic       Key_Pressed;  // accepted frame has any key down

  modport master (
    output Row_In,
    input  Col_Out, Key_Code, Key_Valid, Key_Pressed
  );

  modport slave (
    input  Row_In,
    output Col_Out, Key_Code, Key_Valid, Key_Pressed
  );
endinterface
`default_nettype wire

// File: rtl/keypad_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scan
// Description : 4x4 matrix keypad scanner. Drives one column low at a time,
//               samples the rows into a 16-bit frame, debounces whole frames
//               and reports single key presses as a code plus a strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_scan #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 20
) (
  input  wire logic               CLK,
  input  wire logic               RST,
  keypad_matrix_scan_if.slave     kp
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int STAB_W = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  logic [3:0]        row_s1_q, row_s2_q;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        col_q;
  logic [15:0]       frame_cur_q, frame_prev_q;
  logic              frame_done_q;
  logic [STAB_W-1:0] stable_q;
  state_t            state_q, state_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_pressed_q;

  logic              slot_end_w;
  logic              frame_same_w;
  logic              accept_w;
  logic              frame_any_w;
  logic              frame_one_w;
  logic [3:0]        bit_idx_w;

  assign slot_end_w   = (slot_q == SLOT_W'(SCAN_DIV - 1));
  assign frame_same_w = (frame_cur_q == frame_prev_q);
  // New stable count would be min(stable+1, DEBOUNCE_FRAMES); accept when it hits the top.
  assign accept_w     = frame_done_q && frame_same_w &&
                        (stable_q >= STAB_W'(DEBOUNCE_FRAMES - 1));
  assign frame_any_w  = (frame_cur_q != 16'h0000);
  assign frame_one_w  = frame_any_w && ((frame_cur_q & (frame_cur_q - 16'd1)) == 16'h0000);

  // Two-flop synchronizer for the asynchronous row lines (idle = all high).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= kp.Row_In;
      row_s2_q <= row_s1_q;
    end
  end

  // Slot timer, column rotation and frame capture at the last cycle of each slot.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_q       <= '0;
      col_q        <= 2'd0;
      frame_cur_q  <= 16'h0000;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (slot_end_w) begin
        slot_q                        <= '0;
        col_q                         <= col_q + 2'd1;
        frame_cur_q[{col_q, 2'b00} +: 4] <= ~row_s2_q;
        frame_done_q                  <= (col_q == 2'd3);
      end else begin
        slot_q <= slot_q + SLOT_W'(1);
      end
    end
  end

  // Frame debounce: count consecutive identical frames, restart on any change.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_prev_q <= 16'h0000;
      stable_q     <= '0;
    end else if (frame_done_q) begin
      if (frame_same_w) begin
        if (stable_q != STAB_W'(DEBOUNCE_FRAMES)) begin
          stable_q <= stable_q + STAB_W'(1);
        end
      end else begin
        stable_q     <= '0;
        frame_prev_q <= frame_cur_q;
      end
    end
  end

  // Position of the lowest set frame bit; only meaningful for a one-hot frame.
  always_comb begin
    bit_idx_w = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (frame_cur_q[i]) begin
        bit_idx_w = 4'(i);
      end
    end
  end

  // Press/release FSM, stepped only on an accepted frame.
  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (accept_w) begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_one_w) begin
            // Frame bit is col*4+row; the reported code is row*4+col.
            key_code_d  = {bit_idx_w[1:0], bit_idx_w[3:2]};
            key_valid_d = 1'b1;
            state_d     = ST_HELD;
          end else if (frame_any_w) begin
            state_d = ST_HELD;
          end
        end
        ST_HELD: begin
          if (!frame_any_w) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      if (accept_w) begin
        key_pressed_q <= frame_any_w;
      end
    end
  end

  assign kp.Col_Out     = ~(4'b0001 << col_q);
  assign kp.Key_Code    = key_code_q;
  assign kp.Key_Valid   = key_valid_q;
  assign kp.Key_Pressed = key_pressed_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_matrix_scan
// Description : Self-checking bench for keypad_matrix_scan with a behavioural
//               4x4 keypad (SCAN_DIV=8, DEBOUNCE_FRAMES=3, frame = 32 clk).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scan;

  localparam int FRAME = 32;

  typedef struct {
    logic [15:0] keys;        // key mask indexed by row*4+col
    int          frames;      // frames to hold this mask
    int          exp_pulses;  // Key_Valid strobes expected in that window
    logic [3:0]  exp_code;    // Key_Code at the end of the window
    logic        exp_pressed; // Key_Pressed at the end of the window
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] keys;
  int          cyc;
  int          pulse_cnt;
  int          last_pulse_cyc;
  int          errors;
  int          checks;

  keypad_matrix_scan_if kif ();

  keypad_matrix_scan #(
    .SCAN_DIV        (8),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .kp  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && kif.Key_Valid) begin
      pulse_cnt      <= pulse_cnt + 1;
      last_pulse_cyc <= cyc;
    end
  end

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    kif.Row_In = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !kif.Col_Out[c]) begin
          kif.Row_In[r] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_col(input logic [3:0] target);
    for (int i = 0; i < 64 && kif.Col_Out !== target; i++) tick();
    check("wait_col", {28'd0, kif.Col_Out}, {28'd0, target});
  endtask

  task automatic wait_pulse(input int p0, input int bound);
    for (int i = 0; i < bound && pulse_cnt == p0; i++) tick();
  endtask

  vec_t vecs [9];

  initial begin
    int          p0;
    int          end_cyc;
    logic [3:0]  ecol;
    logic [15:0] m;

    vecs[0] = '{keys: 16'h0000, frames: 6, exp_pulses: 0, exp_code: 4'd9,  exp_pressed: 1'b0};
    vecs[1] = '{keys: 16'h0008, frames: 6, exp_pulses: 1, exp_code: 4'd3,  exp_pressed: 1'b1};
    vecs[2] = '{keys: 16'h0020, frames: 6, exp_pulses: 0, exp_code: 4'd3,  exp_pressed: 1'b1};
    vecs[3] = '{keys: 16'h0000, frames: 6, exp_pulses: 0, exp_code: 4'd3,  exp_pressed: 1'b0};
    vecs[4] = '{keys: 16'h0021, frames: 6, exp_pulses: 0, exp_code: 4'd3,  exp_pressed: 1'b1};
    vecs[5] = '{keys: 16'h0000, frames: 6, exp_pulses: 0, exp_code: 4'd3,  exp_pressed: 1'b0};
    vecs[6] = '{keys: 16'h8000, frames: 6, exp_pulses: 1, exp_code: 4'd15, exp_pressed: 1'b1};
    vecs[7] = '{keys: 16'h0000, frames: 6, exp_pulses: 0, exp_code: 4'd15, exp_pressed: 1'b0};
    vecs[8] = '{keys: 16'h0001, frames: 6, exp_pulses: 1, exp_code: 4'd0,  exp_pressed: 1'b1};

    errors = 0;
    checks = 0;
    keys   = 16'h0000;
    rst    = 1'b0;
    #2 rst = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_col_out",     {28'd0, kif.Col_Out},  32'he);
    check("rst_key_code",    {28'd0, kif.Key_Code}, 32'h0);
    check("rst_key_valid",   {31'd0, kif.Key_Valid},   32'h0);
    check("rst_key_pressed", {31'd0, kif.Key_Pressed}, 32'h0);

    // Column rotation with no keys.
    rst = 1'b0;
    p0  = pulse_cnt;
    for (int k = 1; k <= 64; k++) begin
      tick();
      m    = 16'h0001 << ((k / 8) % 4);
      ecol = ~m[3:0];
      check("col_rotation", {28'd0, kif.Col_Out}, {28'd0, ecol});
    end
    check("idle_no_valid",   pulse_cnt - p0, 32'd0);
    check("idle_no_pressed", {31'd0, kif.Key_Pressed}, 32'h0);

    // Key 9 (row2/col1): one strobe within 5 frames + 2 clk, none while held.
    keys = 16'h0001 << 9;
    p0   = pulse_cnt;
    wait_pulse(p0, 5*FRAME + 2);
    check("k9_valid_in_time", pulse_cnt - p0, 32'd1);
    check("k9_code",          {28'd0, kif.Key_Code},    32'd9);
    check("k9_pressed",       {31'd0, kif.Key_Pressed}, 32'h1);
    p0 = pulse_cnt;
    repeat (6*FRAME) tick();
    check("k9_no_repeat", pulse_cnt - p0, 32'd0);

    // Table: release, presses, held key change, ghosting, corner codes.
    foreach (vecs[i]) begin
      keys = vecs[i].keys;
      p0   = pulse_cnt;
      repeat (vecs[i].frames * FRAME) tick();
      check($sformatf("vec%0d_pulses", i),  pulse_cnt - p0, vecs[i].exp_pulses);
      check($sformatf("vec%0d_code", i),    {28'd0, kif.Key_Code}, {28'd0, vecs[i].exp_code});
      check($sformatf("vec%0d_pressed", i), {31'd0, kif.Key_Pressed}, {31'd0, vecs[i].exp_pressed});
    end
    keys = 16'h0000;
    repeat (6*FRAME) tick();

    // Bounce on key 6 (row1/col2), toggling every 20 clk, aligned to the col2 slot.
    wait_col(4'b1011);
    p0 = pulse_cnt;
    for (int s = 0; s < 4; s++) begin
      keys = (s % 2 == 0) ? (16'h0001 << 6) : 16'h0000;
      repeat (20) tick();
    end
    keys    = 16'h0001 << 6;
    end_cyc = cyc;
    repeat (7*FRAME) tick();
    check("bounce_one_pulse", pulse_cnt - p0, 32'd1);
    check("bounce_code",      {28'd0, kif.Key_Code}, 32'd6);
    check("bounce_not_early", {31'd0, (last_pulse_cyc - end_cyc) >= 3*FRAME}, 32'h1);

    // Reset mid-slot with key 9 held, then re-report after debounce.
    keys = 16'h0000;
    repeat (6*FRAME) tick();
    keys = 16'h0001 << 9;
    p0   = pulse_cnt;
    wait_pulse(p0, 5*FRAME + 2);
    check("pre_rst_k9", pulse_cnt - p0, 32'd1);
    wait_col(4'b1101);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst_col_out",     {28'd0, kif.Col_Out},  32'he);
    check("midrst_key_code",    {28'd0, kif.Key_Code}, 32'h0);
    check("midrst_key_valid",   {31'd0, kif.Key_Valid},   32'h0);
    check("midrst_key_pressed", {31'd0, kif.Key_Pressed}, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    p0  = pulse_cnt;
    wait_pulse(p0, 5*FRAME + 4);
    check("post_rst_valid",   pulse_cnt - p0, 32'd1);
    check("post_rst_code",    {28'd0, kif.Key_Code},    32'd9);
    check("post_rst_pressed", {31'd0, kif.Key_Pressed}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    cyc            = 0;
    pulse_cnt      = 0;
    last_pulse_cyc = 0;
  end

endmodule
`default_nettype wire
